// File: rtl/lbp_write_buf.sv
// Output stage of the LBP pipeline: buffers (address, code) results in a small FIFO,
// zeroes image-border codes and writes them to lbp memory with a valid/ready handshake.
module lbp_write_buf #(
  parameter int unsigned AddrW    = 14,
  parameter int unsigned DataW    = 8,
  parameter int unsigned ImgW     = 128,
  parameter int unsigned Depth    = 4,
  parameter int unsigned LastAddr = 16383
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [AddrW-1:0] in_addr_i,
  input  logic [DataW-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             lbp_valid_o,
  output logic [AddrW-1:0] lbp_addr_o,
  output logic [DataW-1:0] lbp_data_o,
  input  logic             lbp_ready_i,
  output logic             finish_o,
  output logic             order_err_o,
  output logic [AddrW:0]   wr_count_o
);

  localparam int unsigned ColW = $clog2(ImgW);
  localparam int unsigned RowW = AddrW - ColW;
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [AddrW:0] WrMax = {1'b1, {AddrW{1'b0}}};

  logic [AddrW-1:0] addr_q [Depth];
  logic [DataW-1:0] data_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [AddrW:0]   wr_count_q, wr_count_d;
  logic [AddrW-1:0] last_addr_q, last_addr_d;
  logic             last_valid_q, last_valid_d;
  logic             finish_q, finish_d;
  logic             order_err_q, order_err_d;

  logic             full, empty, push, pop, border;
  logic [RowW-1:0]  in_row;
  logic [ColW-1:0]  in_col;
  logic [DataW-1:0] in_data_masked;

  assign in_row = in_addr_i[AddrW-1:ColW];
  assign in_col = in_addr_i[ColW-1:0];
  assign border = (in_row == '0) || (in_row == RowW'(ImgW - 1)) ||
                  (in_col == '0) || (in_col == ColW'(ImgW - 1));
  assign in_data_masked = border ? '0 : in_data_i;

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);

  // Ready depends only on registered state so upstream sees no combinational loop.
  assign in_ready_o  = !full && !finish_q;
  assign lbp_valid_o = !empty;
  assign lbp_addr_o  = addr_q[rptr_q];
  assign lbp_data_o  = data_q[rptr_q];
  assign finish_o    = finish_q;
  assign order_err_o = order_err_q;
  assign wr_count_o  = wr_count_q;

  assign push = in_valid_i && in_ready_o;
  assign pop  = lbp_valid_o && lbp_ready_i;

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    wr_count_d   = wr_count_q;
    last_addr_d  = last_addr_q;
    last_valid_d = last_valid_q;
    finish_d     = finish_q;
    order_err_d  = order_err_q;

    if (push) begin
      wptr_d       = wptr_q + PtrW'(1);
      last_addr_d  = in_addr_i;
      last_valid_d = 1'b1;
      if (last_valid_q && (in_addr_i <= last_addr_q)) begin
        order_err_d = 1'b1;
      end
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
      if (wr_count_q != WrMax) begin
        wr_count_d = wr_count_q + (AddrW + 1)'(1);
      end
      if (lbp_addr_o == AddrW'(LastAddr)) begin
        finish_d = 1'b1;
      end
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      wr_count_q   <= '0;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
      finish_q     <= 1'b0;
      order_err_q  <= 1'b0;
    end else begin
      if (push) begin
        addr_q[wptr_q] <= in_addr_i;
        data_q[wptr_q] <= in_data_masked;
      end
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      wr_count_q   <= wr_count_d;
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
      finish_q     <= finish_d;
      order_err_q  <= order_err_d;
    end
  end

endmodule

// File: tb/tb_lbp_write_buf.sv
// Bench for lbp_write_buf: table vectors, hand sequences and a random full-image stream,
// all checked against a queue-based reference of the buffer's external behaviour.
module tb_lbp_write_buf;

  localparam int DEPTH   = 4;
  localparam int NPIX    = 16384;
  localparam int LAST    = 16383;
  localparam int MAXCYC  = 80000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [13:0] in_addr;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        lbp_ready;
  logic        finish;
  logic        order_err;
  logic [14:0] wr_count;

  always #5 clk = ~clk;

  lbp_write_buf dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_addr_i   (in_addr),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .lbp_valid_o (lbp_valid),
    .lbp_addr_o  (lbp_addr),
    .lbp_data_o  (lbp_data),
    .lbp_ready_i (lbp_ready),
    .finish_o    (finish),
    .order_err_o (order_err),
    .wr_count_o  (wr_count)
  );

  typedef struct packed {
    logic [13:0] a;
    logic [7:0]  d;
  } ent_t;

  typedef struct {
    logic [13:0] a;
    logic [7:0]  d;
    logic [7:0]  exp;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;

  // Reference: what the memory should see, in order, plus the sticky flags.
  ent_t mq[$];
  bit   m_fin, m_err, m_last_v;
  int   m_last, m_wc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_data(input int a, input logic [7:0] d);
    int row, col;
    row = a / 128;
    col = a % 128;
    if (row == 0 || row == 127 || col == 0 || col == 127) return 8'h00;
    return d;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_fin    = 1'b0;
    m_err    = 1'b0;
    m_last_v = 1'b0;
    m_last   = 0;
    m_wc     = 0;
  endtask

  task automatic check_model();
    chk("in_ready", in_ready, (mq.size() < DEPTH) && !m_fin);
    chk("lbp_valid", lbp_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("lbp_addr", lbp_addr, mq[0].a);
      chk("lbp_data", lbp_data, mq[0].d);
    end
    chk("finish", finish, m_fin);
    chk("order_err", order_err, m_err);
    chk("wr_count", wr_count, m_wc);
  endtask

  // Drive one cycle at a negedge, let the posedge pass, update the reference and compare.
  task automatic step(input bit v, input int a, input logic [7:0] d, input bit r,
                      output bit pushed, output bit popped);
    ent_t head;
    in_valid  = v;
    in_addr   = a[13:0];
    in_data   = d;
    lbp_ready = r;
    pushed = v && (mq.size() < DEPTH) && !m_fin;
    popped = r && (mq.size() > 0);
    @(negedge clk);
    if (popped) begin
      head = mq.pop_front();
      if (m_wc < NPIX) m_wc++;
      if (int'(head.a) == LAST) m_fin = 1'b1;
    end
    if (pushed) begin
      if (m_last_v && a <= m_last) m_err = 1'b1;
      m_last   = a;
      m_last_v = 1'b1;
      mq.push_back('{a: a[13:0], d: ref_data(a, d)});
    end
    check_model();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    lbp_ready = 1'b0;
    rst_n     = 1'b0;
    #3;
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    check_model();
  endtask

  initial begin
    vec_t tbl[8];
    bit   pu, po;
    int   next, cyc, nwr;

    tbl[0] = '{a: 14'd0,     d: 8'hFF, exp: 8'h00};
    tbl[1] = '{a: 14'd127,   d: 8'hFF, exp: 8'h00};
    tbl[2] = '{a: 14'd128,   d: 8'hFF, exp: 8'h00};
    tbl[3] = '{a: 14'd16256, d: 8'hFF, exp: 8'h00};
    tbl[4] = '{a: 14'd255,   d: 8'hFF, exp: 8'h00};
    tbl[5] = '{a: 14'd130,   d: 8'hFF, exp: 8'hFF};
    tbl[6] = '{a: 14'd254,   d: 8'h3C, exp: 8'h3C};
    tbl[7] = '{a: 14'd16254, d: 8'hA5, exp: 8'hA5};

    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    lbp_ready = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    #12;
    chk("rst_lbp_valid", lbp_valid, 0);
    chk("rst_lbp_addr", lbp_addr, 0);
    chk("rst_lbp_data", lbp_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_count", wr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single push, 1-cycle latency, popped immediately.
    step(1, 129, 8'h5A, 1, pu, po);
    chk("single_valid", lbp_valid, 1);
    chk("single_addr", lbp_addr, 129);
    chk("single_data", lbp_data, 8'h5A);
    step(0, 0, 8'h00, 1, pu, po);
    chk("single_wr_count", wr_count, 1);
    chk("single_empty", lbp_valid, 0);

    // Border forcing table.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, int'(tbl[i].a), tbl[i].d, 1, pu, po);
      chk("tbl_valid", lbp_valid, 1);
      chk("tbl_addr", lbp_addr, tbl[i].a);
      chk("tbl_data", lbp_data, tbl[i].exp);
      step(0, 0, 8'h00, 1, pu, po);
    end
    chk("tbl_wr_count", wr_count, 8);

    // Backpressure: four accepted, fifth refused, head held stable.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 200 + (i < 4 ? i : 4), 8'h40 + 8'(i), 0, pu, po);
    end
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_head_hold", lbp_addr, 200);
    cyc = 0;
    nwr = 0;
    pu  = 1'b0;
    while (!pu && cyc < 10) begin
      step(1, 204, 8'h44, 1, pu, po);
      if (po) nwr++;
      cyc++;
    end
    chk("bp_204_accepted", pu, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 8'h00, 1, pu, po);
      if (po) nwr++;
    end
    chk("bp_writes", nwr, 5);

    // Out-of-order addresses.
    do_reset();
    step(1, 500, 8'h11, 1, pu, po);
    step(1, 499, 8'h22, 1, pu, po);
    chk("oe_set", order_err, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, pu, po);
    chk("oe_sticky", order_err, 1);
    chk("oe_both_written", wr_count, 2);

    // Async reset with three buffered entries.
    do_reset();
    step(1, 1002, 8'h01, 0, pu, po);
    step(1, 1001, 8'h02, 1, pu, po);
    step(1, 1000, 8'h03, 0, pu, po);
    step(1, 999, 8'h04, 0, pu, po);
    chk("ar_pre_wr_count", wr_count, 1);
    chk("ar_pre_order_err", order_err, 1);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_lbp_valid", lbp_valid, 0);
    chk("ar_order_err", order_err, 0);
    chk("ar_wr_count", wr_count, 0);
    chk("ar_finish", finish, 0);
    model_reset();
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_model();
    chk("ar_in_ready", in_ready, 1);

    // Full random stream over the whole image.
    do_reset();
    next = 0;
    cyc  = 0;
    nwr  = 0;
    while ((next < NPIX || mq.size() > 0) && cyc < MAXCYC) begin
      bit last_pop;
      last_pop = (mq.size() > 0) && (int'(mq[0].a) == LAST);
      step(next < NPIX && $urandom_range(0, 3) != 0, next, 8'($urandom),
           1'($urandom_range(0, 1)), pu, po);
      if (pu) next++;
      if (po) begin
        nwr++;
        if (last_pop) chk("fs_finish_edge", finish, 1);
      end
      cyc++;
    end
    chk("fs_all_pushed", next, NPIX);
    chk("fs_writes", nwr, NPIX);
    chk("fs_finish", finish, 1);
    chk("fs_wr_count", wr_count, NPIX);
    for (int i = 0; i < 5; i++) step(1, 5, 8'h77, 1, pu, po);
    chk("fs_ignored_ready", in_ready, 0);
    chk("fs_ignored_valid", lbp_valid, 0);
    do_reset();
    chk("fs_reset_finish", finish, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
